adc_capture_window: RTL and testbench

//  Triggered capture of the 128-bit ADC AXIS stream (8 x 16-bit samples/beat) for PS readback over DMA.

---
 rtl/adc_capture_window.sv | 175 +++++++++++++++++
 tb/tb_adc_capture_window.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_capture_window.sv
// Triggered capture window on the ADC AXIS stream: skip a programmable number of
// valid beats after a trigger edge, store a window, then drain it as a framed AXIS packet.
module adc_capture_window #(
  parameter int DEPTH          = 1024,
  parameter int DATA_W         = 128,
  parameter int DELAY_REG_BASE = 4,
  parameter int LEN_REG_BASE   = 6,
  parameter int CLR_REG_ADDR   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       gpio_in,
  input  logic              trig_in,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic              busy,
  output logic              done,
  output logic              missed_trig
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [15:0] A_DLY_LO = 16'(DELAY_REG_BASE);
  localparam logic [15:0] A_DLY_HI = 16'(DELAY_REG_BASE + 1);
  localparam logic [15:0] A_LEN_LO = 16'(LEN_REG_BASE);
  localparam logic [15:0] A_LEN_HI = 16'(LEN_REG_BASE + 1);
  localparam logic [15:0] A_CLR    = 16'(CLR_REG_ADDR);

  typedef enum logic [2:0] {S_IDLE, S_DELAY, S_CAPTURE, S_DRAIN, S_WAIT_LOW} state_t;

  state_t            r_state, w_state_n;
  logic              r_wclk_s1, r_wclk_s2, r_wclk_s3;
  logic              w_wr_stb, w_clr, w_trig_edge, w_unused;
  logic [15:0]       w_gpio_addr;
  logic [7:0]        w_gpio_data;
  logic [15:0]       r_delay, r_len, r_dly_cnt;
  logic              r_trig_d;
  logic [AW-1:0]     r_last_idx, r_wr_ptr, r_rd_ptr;
  logic [AW:0]       r_beat_cnt, r_rd_cnt;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_mem_q_p1;
  logic              r_vld_p1, r_last_p1, r_done, r_missed;
  logic              w_start, w_mem_we, w_rd_en, w_issue, w_last_hs;

  // Window length 0 or beyond the buffer means a full buffer.
  function automatic logic [AW-1:0] f_last_idx(input logic [15:0] len);
    if (len == 16'd0 || 32'(len) >= DEPTH) return AW'(DEPTH - 1);
    return AW'(len - 16'd1);
  endfunction

  assign w_gpio_addr = gpio_in[15:0];
  assign w_gpio_data = gpio_in[23:16];
  assign w_unused    = &{1'b0, gpio_in[31:25]};
  assign w_wr_stb    = r_wclk_s2 & ~r_wclk_s3;
  assign w_clr       = w_wr_stb & (w_gpio_addr == A_CLR);
  assign w_trig_edge = trig_in & ~r_trig_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    w_start   = 1'b0;
    w_mem_we  = 1'b0;
    w_rd_en   = 1'b0;
    w_issue   = 1'b0;
    w_last_hs = r_vld_p1 & m_axis_tready & r_last_p1;
    unique case (r_state)
      S_IDLE: begin
        if (w_trig_edge) begin
          w_start   = 1'b1;
          w_state_n = (r_delay != 16'd0) ? S_DELAY : S_CAPTURE;
        end
      end
      S_DELAY: begin
        if (s_axis_tvalid && r_dly_cnt == 16'd1) w_state_n = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (s_axis_tvalid) begin
          w_mem_we = 1'b1;
          if (r_beat_cnt == {1'b0, r_last_idx}) w_state_n = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // The RAM output register doubles as the AXIS output stage; it only advances when free.
        w_rd_en = ~r_vld_p1 | m_axis_tready;
        w_issue = w_rd_en & (r_rd_cnt <= {1'b0, r_last_idx});
        if (w_last_hs) w_state_n = S_WAIT_LOW;
      end
      S_WAIT_LOW: begin
        if (!trig_in) w_state_n = S_IDLE;
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wclk_s1  <= 1'b0;
      r_wclk_s2  <= 1'b0;
      r_wclk_s3  <= 1'b0;
      r_trig_d   <= 1'b0;
      r_delay    <= '0;
      r_len      <= '0;
      r_dly_cnt  <= '0;
      r_last_idx <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_beat_cnt <= '0;
      r_rd_cnt   <= '0;
      r_vld_p1   <= 1'b0;
      r_last_p1  <= 1'b0;
      r_done     <= 1'b0;
      r_missed   <= 1'b0;
    end else begin
      r_wclk_s1 <= gpio_in[24];
      r_wclk_s2 <= r_wclk_s1;
      r_wclk_s3 <= r_wclk_s2;
      r_trig_d  <= trig_in;
      if (w_wr_stb) begin
        if (w_gpio_addr == A_DLY_LO) r_delay[7:0]  <= w_gpio_data;
        if (w_gpio_addr == A_DLY_HI) r_delay[15:8] <= w_gpio_data;
        if (w_gpio_addr == A_LEN_LO) r_len[7:0]    <= w_gpio_data;
        if (w_gpio_addr == A_LEN_HI) r_len[15:8]   <= w_gpio_data;
      end
      if (w_trig_edge && r_state != S_IDLE) r_missed <= 1'b1;
      else if (w_clr)                       r_missed <= 1'b0;
      r_done <= w_last_hs;

      if (w_start) begin
        r_dly_cnt  <= r_delay;
        r_last_idx <= f_last_idx(r_len);
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
        r_beat_cnt <= '0;
        r_rd_cnt   <= '0;
      end
      if (r_state == S_DELAY && s_axis_tvalid) r_dly_cnt <= r_dly_cnt - 16'd1;
      if (w_mem_we) begin
        r_wr_ptr   <= r_wr_ptr + AW'(1);
        r_beat_cnt <= r_beat_cnt + (AW+1)'(1);
      end

      // Stage p1: RAM read data presented on the AXIS master
      if (w_rd_en) begin
        r_vld_p1  <= w_issue;
        r_last_p1 <= w_issue && (r_rd_cnt == {1'b0, r_last_idx});
        if (w_issue) begin
          r_rd_ptr <= r_rd_ptr + AW'(1);
          r_rd_cnt <= r_rd_cnt + (AW+1)'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[r_wr_ptr] <= s_axis_tdata;
    if (w_issue)  r_mem_q_p1 <= r_mem[r_rd_ptr];
  end

  assign s_axis_tready = 1'b1;
  assign m_axis_tdata  = r_vld_p1 ? r_mem_q_p1 : '0;
  assign m_axis_tvalid = r_vld_p1;
  assign m_axis_tlast  = r_last_p1;
  assign busy          = (r_state != S_IDLE);
  assign done          = r_done;
  assign missed_trig   = r_missed;

endmodule

// File: tb/tb_adc_capture_window.sv
// Randomised bench for adc_capture_window: an in-bench window model predicts every
// output beat, done pulse, busy and missed_trig level, plus literal checks per scenario.
module tb_adc_capture_window;
  localparam int DEPTH = 1024;
  localparam int DW    = 128;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   gpio_in;
  logic          trig_in;
  logic [DW-1:0] s_tdata;
  logic          s_tvalid;
  logic          s_tready;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready;
  logic          m_tlast;
  logic          busy, done, missed;

  always #5 clk = ~clk;

  adc_capture_window #(.DEPTH(DEPTH), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .gpio_in(gpio_in), .trig_in(trig_in),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .m_axis_tlast(m_tlast), .busy(busy), .done(done), .missed_trig(missed)
  );

  int n_chk = 0, n_fail = 0, n_done = 0;
  logic [DW-1:0] out_log[$];
  logic          last_log[$];

  int unsigned vld_pct = 0, rdy_pct = 0;
  bit          alt_mode = 0, cnt_data = 0;
  int          beat_k = 0;
  logic [DW-1:0] data_base = '0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, expv);
    end
  endtask

  function automatic int win_len(input int len);
    return (len == 0 || len >= DEPTH) ? DEPTH : len;
  endfunction

  function automatic logic [DW-1:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic tick();
    @(posedge clk); #1;
    beat_k++;
    s_tvalid = alt_mode ? (beat_k % 2 == 0) : ($urandom_range(99) < vld_pct);
    if (cnt_data && s_tvalid) s_tdata = data_base + DW'(beat_k);
    else                      s_tdata = rnd128();
    m_tready = ($urandom_range(99) < rdy_pct);
  endtask

  task automatic wr(input int addr, input int data);
    gpio_in = {7'd0, 1'b0, 8'(data), 16'(addr)};
    tick();
    gpio_in[24] = 1'b1;
    repeat (3) tick();
    gpio_in[24] = 1'b0;
    repeat (3) tick();
  endtask

  task automatic cfg(input int dly, input int len);
    wr(4, dly & 255); wr(5, (dly >> 8) & 255);
    wr(6, len & 255); wr(7, (len >> 8) & 255);
  endtask

  task automatic wait_done(input int budget, input string nm);
    int start = n_done;
    bit ok = 0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (n_done != start) begin ok = 1; break; end
    end
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: no done pulse within %0d cycles", nm, budget);
    end
  endtask

  task automatic end_window();
    trig_in = 1'b0;
    repeat (4) tick();
  endtask

  // ---------------- behavioural model + per-cycle compare ----------------
  bit m_busy, m_wait, m_coll, m_missed, m_done, m_first;
  int m_skip, m_L, m_ncol, m_ndrn, m_age;
  logic [DW-1:0] m_exp[$];
  logic [15:0] cfg_dly, cfg_len;
  bit p_trig, w1, w2, w3;
  bit pv_vld, pv_rdy, pv_lasths;
  logic [DW-1:0] pv_data;
  logic pv_last;
  bit hs, hs_last, edg, stb, busy0, setm, clr;
  logic [DW-1:0] e;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_tvalid", 128'(m_tvalid), 128'(0));
      chk("rst_tlast", 128'(m_tlast), 128'(0));
      chk("rst_tdata", m_tdata, 128'(0));
      chk("rst_busy", 128'(busy), 128'(0));
      chk("rst_done", 128'(done), 128'(0));
      chk("rst_missed", 128'(missed), 128'(0));
      chk("rst_s_tready", 128'(s_tready), 128'(1));
      m_busy = 0; m_wait = 0; m_coll = 0; m_missed = 0; m_done = 0; m_first = 0;
      m_exp.delete(); cfg_dly = '0; cfg_len = '0;
      p_trig = 0; w1 = 0; w2 = 0; w3 = 0;
      pv_vld = 0; pv_rdy = 0; pv_lasths = 0;
    end else begin
      chk("s_tready", 128'(s_tready), 128'(1));
      chk("busy", 128'(busy), 128'(m_busy));
      chk("done", 128'(done), 128'(m_done));
      chk("missed_trig", 128'(missed), 128'(m_missed));
      if (m_done) n_done++;
      if (!m_busy || m_coll) chk("tvalid_outside_drain", 128'(m_tvalid), 128'(0));
      if (pv_vld && !pv_rdy) begin
        chk("stall_tdata", m_tdata, pv_data);
        chk("stall_tlast", 128'(m_tlast), 128'(pv_last));
      end
      if (pv_vld && !pv_lasths) chk("no_bubble", 128'(m_tvalid), 128'(1));
      if (m_first) begin
        if (m_tvalid) m_first = 0;
        else begin
          chk("first_beat_latency", 128'(m_age >= 2), 128'(0));
          m_age++;
        end
      end
      hs = m_tvalid && m_tready;
      hs_last = 0;
      if (hs) begin
        out_log.push_back(m_tdata);
        last_log.push_back(m_tlast);
        if (m_exp.size() == 0) chk("spurious_beat", 128'(1), 128'(0));
        else begin
          e = m_exp.pop_front();
          m_ndrn++;
          hs_last = (m_ndrn == m_L);
          chk("tdata", m_tdata, e);
          chk("tlast", 128'(m_tlast), 128'(hs_last));
        end
      end
      pv_vld = m_tvalid; pv_rdy = m_tready; pv_data = m_tdata; pv_last = m_tlast;
      pv_lasths = hs_last;

      // advance the model across the coming clock edge
      edg = trig_in && !p_trig; p_trig = trig_in;
      stb = w2 && !w3; w3 = w2; w2 = w1; w1 = gpio_in[24];
      busy0 = m_busy; setm = 0; clr = 0; m_done = 0;
      if (m_wait && !trig_in) begin m_busy = 0; m_wait = 0; end
      if (hs_last) begin m_wait = 1; m_done = 1; end
      if (m_coll && s_tvalid) begin
        if (m_skip > 0) m_skip--;
        else begin
          m_exp.push_back(s_tdata);
          m_ncol++;
          if (m_ncol == m_L) begin m_coll = 0; m_first = 1; m_age = 0; end
        end
      end
      if (edg) begin
        if (!busy0) begin
          m_busy = 1; m_coll = 1; m_skip = int'(cfg_dly); m_L = win_len(int'(cfg_len));
          m_ncol = 0; m_ndrn = 0; m_exp.delete();
        end else setm = 1;
      end
      if (stb) begin
        case (gpio_in[15:0])
          16'd4: cfg_dly[7:0]  = gpio_in[23:16];
          16'd5: cfg_dly[15:8] = gpio_in[23:16];
          16'd6: cfg_len[7:0]  = gpio_in[23:16];
          16'd7: cfg_len[15:8] = gpio_in[23:16];
          16'd8: clr = 1;
          default: ;
        endcase
      end
      if (clr)  m_missed = 0;
      if (setm) m_missed = 1;
    end
  end

  // ---------------- scenarios ----------------
  initial begin
    int st_done, nl, dly, len;
    rst = 1'b1; gpio_in = '0; trig_in = 1'b0; s_tdata = '0; s_tvalid = 1'b0; m_tready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    repeat (2) tick();

    // 1: delay 0, len 4, trigger alongside beat 5
    cfg(0, 4);
    vld_pct = 100; rdy_pct = 100; cnt_data = 1; data_base = 128'd1000; beat_k = -1;
    out_log.delete(); last_log.delete(); st_done = n_done;
    do tick(); while (beat_k != 5);
    trig_in = 1'b1;
    wait_done(60, "t1_done");
    end_window();
    chk("t1_count", 128'(out_log.size()), 128'(4));
    for (int i = 0; i < 4 && i < out_log.size(); i++) begin
      chk("t1_data", out_log[i], 128'(1006 + i));
      chk("t1_last", 128'(last_log[i]), 128'(i == 3));
    end
    chk("t1_done_pulses", 128'(n_done - st_done), 128'(1));

    // 2: delay 3, len 2, tvalid alternating
    cfg(3, 2);
    alt_mode = 1; data_base = 128'd2000; beat_k = -1;
    out_log.delete(); last_log.delete();
    do tick(); while (beat_k != 0);
    trig_in = 1'b1;
    wait_done(80, "t2_done");
    end_window();
    alt_mode = 0; cnt_data = 0;
    chk("t2_count", 128'(out_log.size()), 128'(2));
    if (out_log.size() == 2) begin
      chk("t2_beat0", out_log[0], 128'd2008);
      chk("t2_beat1", out_log[1], 128'd2010);
    end

    // 3: len 0 gives a full buffer across the pointer wrap
    cfg(0, 0);
    vld_pct = 75; rdy_pct = 100;
    out_log.delete(); last_log.delete();
    trig_in = 1'b1;
    wait_done(6000, "t3_done");
    end_window();
    chk("t3_count", 128'(out_log.size()), 128'(DEPTH));
    nl = 0;
    foreach (last_log[i]) if (last_log[i]) nl++;
    chk("t3_tlast_count", 128'(nl), 128'(1));
    if (last_log.size() == DEPTH) chk("t3_tlast_pos", 128'(last_log[DEPTH-1]), 128'(1));

    // 4: random config with random backpressure
    for (int it = 0; it < 5; it++) begin
      dly = $urandom_range(0, 5);
      len = (it == 4) ? 1030 : $urandom_range(1, 40);
      cfg(dly, len);
      vld_pct = 60; rdy_pct = 40;
      out_log.delete(); last_log.delete();
      repeat ($urandom_range(0, 5)) tick();
      trig_in = 1'b1;
      wait_done(8000, "t4_done");
      end_window();
      chk("t4_count", 128'(out_log.size()), 128'(win_len(len)));
    end

    // 5: second edge during a window, clear, and set-beats-clear
    cfg(2, 20);
    vld_pct = 0; rdy_pct = 100;
    out_log.delete(); last_log.delete();
    trig_in = 1'b1; repeat (3) tick();
    trig_in = 1'b0; tick();
    trig_in = 1'b1; repeat (4) tick();
    chk("t5_missed_set", 128'(missed), 128'(1));
    wr(8, 0);
    chk("t5_missed_clr", 128'(missed), 128'(0));
    gpio_in = {7'd0, 1'b1, 8'd0, 16'd8}; trig_in = 1'b0; tick();
    tick();
    trig_in = 1'b1; repeat (3) tick();
    gpio_in[24] = 1'b0; repeat (3) tick();
    chk("t5_set_wins", 128'(missed), 128'(1));
    vld_pct = 100;
    wait_done(200, "t5_done");
    end_window();
    chk("t5_count", 128'(out_log.size()), 128'(20));
    wr(8, 0);
    chk("t5_missed_final", 128'(missed), 128'(0));

    // 6: reset in the middle of draining, then a fresh full window
    cfg(0, 50);
    vld_pct = 100; rdy_pct = 100;
    out_log.delete(); last_log.delete();
    trig_in = 1'b1;
    for (int i = 0; i < 200 && out_log.size() < 10; i++) tick();
    chk("t6_reached_drain", 128'(out_log.size() >= 10), 128'(1));
    rst = 1'b1; #1;
    chk("t6_tvalid_now", 128'(m_tvalid), 128'(0));
    chk("t6_busy_now", 128'(busy), 128'(0));
    tick(); tick();
    trig_in = 1'b0; rst = 1'b0;
    repeat (3) tick();
    vld_pct = 80; rdy_pct = 70;
    out_log.delete(); last_log.delete();
    trig_in = 1'b1;
    wait_done(6000, "t6_done");
    end_window();
    chk("t6_count", 128'(out_log.size()), 128'(DEPTH));
    if (last_log.size() == DEPTH) chk("t6_tlast_pos", 128'(last_log[DEPTH-1]), 128'(1));

    chk("end_busy", 128'(busy), 128'(0));
    chk("end_pending", 128'(m_exp.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
